// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage wrapped around an external 32-bit PC register.
// Reads the current PC, drives the next PC, keeps at most one instruction
// memory request outstanding, and buffers returned words in a circular queue
// of QDEPTH entries for decode. A redirect flushes the queue, steers the PC,
// and causes any in-flight response to be discarded. The PC register has no
// enable, so the PC is stalled by driving o_npc = i_pc.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned PC in IDLE blocks issue and sets o_if_misalign,
//               which stays set until a redirect or reset.
//   undefined : o_if_misalign is tied low; low PC bits are ignored for issue.
//
// Parameters
//   QDEPTH        instruction queue depth (2 or 4)
// Ports
//   clk           clock, rising edge
//   clrn          asynchronous reset, active high
//   i_pc          current PC from the PC register
//   o_npc         next PC to the PC register
//   o_imem_req    memory request valid
//   o_imem_addr   memory request address (always i_pc)
//   i_imem_gnt    memory accepts the request this cycle
//   i_imem_rvalid memory read data valid
//   i_imem_rdata  instruction word
//   i_redirect    branch/jump taken (highest priority)
//   i_redirect_pc redirect target
//   o_id_valid    queue head valid
//   o_id_inst     queue head instruction
//   o_id_pc       PC of the queue head
//   i_id_ready    decode accepts the head this cycle
//   o_if_misalign misaligned PC flag
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int QDEPTH = 2
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] i_pc,
   output logic [31:0] o_npc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_id_valid,
   output logic [31:0] o_id_inst,
   output logic [31:0] o_id_pc,
   input  logic        i_id_ready,
   output logic        o_if_misalign
);

   localparam int PW = (QDEPTH > 2) ? 2 : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [31:0]   r_req_pc;
   logic [31:0]   r_q_inst [QDEPTH];
   logic [31:0]   r_q_pc   [QDEPTH];

   logic w_mis_block;
   logic w_req;
   logic w_acc;
   logic w_push;
   logic w_pop;

`ifdef FETCH_ALIGN_CHECK_EN
   logic r_misalign;
   assign w_mis_block = (i_pc[1:0] != 2'b00);
`else
   assign w_mis_block = 1'b0;
`endif

   // Issue only uses the registered occupancy: a same-cycle pop does not
   // free a slot, so every issued request already owns a queue entry.
   assign w_req  = (r_state == ST_IDLE) && (r_count < CW'(QDEPTH)) &&
                   !i_redirect && !clrn && !w_mis_block;
   assign w_acc  = w_req && i_imem_gnt;
   assign w_push = (r_state == ST_WAIT) && i_imem_rvalid && !i_redirect;
   assign w_pop  = (r_count != {CW{1'b0}}) && i_id_ready && !i_redirect;

   assign o_imem_req  = w_req;
   assign o_imem_addr = i_pc;
   assign o_npc       = i_redirect ? i_redirect_pc :
                        (w_acc ? (i_pc + 32'd4) : i_pc);
   assign o_id_valid  = (r_count != {CW{1'b0}});
   assign o_id_inst   = r_q_inst[r_rptr];
   assign o_id_pc     = r_q_pc[r_rptr];

   // Request FSM: tracks the single outstanding request and whether its
   // response must be thrown away after a redirect.
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         r_state  <= ST_IDLE;
         r_req_pc <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_acc) begin
                  r_state  <= ST_WAIT;
                  r_req_pc <= i_pc;
               end
            end
            ST_WAIT: begin
               // A response coinciding with a redirect is consumed (and
               // discarded), so nothing is left to drop.
               if (i_imem_rvalid) begin
                  r_state <= ST_IDLE;
               end else if (i_redirect) begin
                  r_state <= ST_DROP;
               end
            end
            ST_DROP: begin
               if (i_imem_rvalid) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Instruction queue: circular buffer with occupancy counter, flushed by redirect.
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         r_count <= {CW{1'b0}};
         r_wptr  <= {PW{1'b0}};
         r_rptr  <= {PW{1'b0}};
         for (int i = 0; i < QDEPTH; i++) begin
            r_q_inst[i] <= 32'd0;
            r_q_pc[i]   <= 32'd0;
         end
      end else if (i_redirect) begin
         r_count <= {CW{1'b0}};
         r_wptr  <= {PW{1'b0}};
         r_rptr  <= {PW{1'b0}};
      end else begin
         if (w_push) begin
            r_q_inst[r_wptr] <= i_imem_rdata;
            r_q_pc[r_wptr]   <= r_req_pc;
            r_wptr           <= r_wptr + {{(PW-1){1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rptr <= r_rptr + {{(PW-1){1'b0}}, 1'b1};
         end
         r_count <= r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   // Misalignment flag: sticky until the next redirect.
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         r_misalign <= 1'b0;
      end else if (i_redirect) begin
         r_misalign <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_mis_block) begin
         r_misalign <= 1'b1;
      end
   end
   assign o_if_misalign = r_misalign;
`else
   assign o_if_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. The bench owns the PC register and a
// memory responder, and keeps a transaction-level reference model: a queue of
// {pc, inst} entries decode should see, plus an outstanding/killed flag for
// the single in-flight request. Directed sequences follow the test plan, then
// randomized traffic runs against the same model.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int QDEPTH = 2;

   logic        clk;
   logic        clrn;
   logic [31:0] pc;
   logic [31:0] npc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        id_ready;
   logic        if_misalign;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [63:0] mq[$];
   bit          m_busy;
   bit          m_kill;
   logic [31:0] m_req_pc;
   bit          m_mis;

   // memory responder state
   bit          mem_pend;
   logic [31:0] mem_addr;
   int          mem_cnt;
   int          lat;

   // observation counters for directed checks
   int          g_cnt;
   logic [31:0] g_first;
   int          d_cnt;
   logic [31:0] d_first;
   bit          seq_on;
   logic [31:0] seq_pc;

   fetch_unit #(.QDEPTH(QDEPTH)) dut (
      .clk           (clk),
      .clrn          (clrn),
      .i_pc          (pc),
      .o_npc         (npc),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_gnt    (gnt),
      .i_imem_rvalid (rvalid),
      .i_imem_rdata  (rdata),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_id_valid    (id_valid),
      .o_id_inst     (id_inst),
      .o_id_pc       (id_pc),
      .i_id_ready    (id_ready),
      .o_if_misalign (if_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register, held at zero by reset
   always @(posedge clk or posedge clrn) begin
      if (clrn) pc <= 32'd0;
      else      pc <= npc;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_obs();
      g_cnt   = 0;
      g_first = 32'hDEAD_BEEF;
      d_cnt   = 0;
      d_first = 32'hDEAD_BEEF;
   endtask

   task automatic model_reset();
      mq.delete();
      m_busy   = 1'b0;
      m_kill   = 1'b0;
      m_req_pc = 32'd0;
      m_mis    = 1'b0;
   endtask

   task automatic do_reset();
      clrn        = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      gnt         = 1'b1;
      id_ready    = 1'b1;
      rvalid      = 1'b0;
      mem_pend    = 1'b0;
      seq_on      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      clear_obs();
      clrn = 1'b0;
   endtask

   // One clock cycle: memory drives its response, outputs are checked at the
   // falling edge against the model, then model and memory advance.
   task automatic step();
      bit          e_req;
      bit          e_pop;
      logic [31:0] e_npc;
      if (mem_pend && mem_cnt == 0) begin
         rvalid = 1'b1;
         rdata  = mem_addr ^ 32'hA5A5_0000;
      end else begin
         rvalid = 1'b0;
         rdata  = $urandom;
         if (mem_pend) mem_cnt = mem_cnt - 1;
      end
      @(negedge clk);
      e_req = !m_busy && (mq.size() < QDEPTH) && !redirect;
`ifdef FETCH_ALIGN_CHECK_EN
      if (pc[1:0] != 2'b00) e_req = 1'b0;
`endif
      e_npc = redirect ? redirect_pc : ((e_req && gnt) ? pc + 32'd4 : pc);
      check_eq("imem_req", {31'd0, imem_req}, {31'd0, e_req});
      check_eq("imem_addr", imem_addr, pc);
      check_eq("npc", npc, e_npc);
      check_eq("id_valid", {31'd0, id_valid}, {31'd0, (mq.size() != 0)});
      if (mq.size() != 0) begin
         check_eq("id_pc", id_pc, mq[0][63:32]);
         check_eq("id_inst", id_inst, mq[0][31:0]);
      end
      check_eq("if_misalign", {31'd0, if_misalign}, {31'd0, m_mis});
      if (imem_req && gnt) begin
         if (g_cnt == 0) g_first = pc;
         g_cnt++;
      end
      if (id_valid && id_ready && !redirect) begin
         if (d_cnt == 0) d_first = id_pc;
         d_cnt++;
         if (seq_on) begin
            check_eq("seq_pc", id_pc, seq_pc);
            check_eq("seq_inst", id_inst, seq_pc ^ 32'hA5A5_0000);
            seq_pc = seq_pc + 32'd4;
         end
      end
      // model update
      e_pop = (mq.size() != 0) && id_ready && !redirect;
      if (redirect) m_mis = 1'b0;
      else if (!m_busy && pc[1:0] != 2'b00) begin
`ifdef FETCH_ALIGN_CHECK_EN
         m_mis = 1'b1;
`endif
      end
      if (redirect) mq.delete();
      else if (e_pop) void'(mq.pop_front());
      if (m_busy && rvalid) begin
         if (!m_kill && !redirect) mq.push_back({m_req_pc, rdata});
         m_busy = 1'b0;
         m_kill = 1'b0;
      end else if (m_busy && redirect) begin
         m_kill = 1'b1;
      end
      if (e_req && gnt) begin
         m_busy   = 1'b1;
         m_kill   = 1'b0;
         m_req_pc = pc;
      end
      // memory bookkeeping
      if (rvalid) mem_pend = 1'b0;
      if (imem_req && gnt) begin
         mem_pend = 1'b1;
         mem_addr = imem_addr;
         mem_cnt  = lat;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      clrn        = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      gnt         = 1'b1;
      id_ready    = 1'b1;
      rvalid      = 1'b0;
      rdata       = 32'd0;
      lat         = 0;
      mem_pend    = 1'b0;
      mem_cnt     = 0;
      mem_addr    = 32'd0;
      seq_on      = 1'b0;
      seq_pc      = 32'd0;
      model_reset();
      clear_obs();

      // reset values
      #3;
      check_eq("rst_id_valid", {31'd0, id_valid}, 32'd0);
      check_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check_eq("rst_id_inst", id_inst, 32'd0);
      check_eq("rst_id_pc", id_pc, 32'd0);
      check_eq("rst_misalign", {31'd0, if_misalign}, 32'd0);
      check_eq("rst_npc", npc, 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0040;
      #1;
      check_eq("rst_npc_redirect", npc, 32'h0000_0040);
      redirect = 1'b0;

      // streaming with single-cycle memory, decode always ready
      do_reset();
      lat    = 0;
      seq_on = 1'b1;
      seq_pc = 32'd0;
      run_n(24);
      check_eq("stream_pops", d_cnt, 11);
      seq_on = 1'b0;

      // decode stalled: queue fills, fetch stops, then resumes at 8
      do_reset();
      id_ready = 1'b0;
      run_n(10);
      check_eq("stall_grants", g_cnt, 2);
      check_eq("stall_req", {31'd0, imem_req}, 32'd0);
      check_eq("stall_npc", npc, pc);
      clear_obs();
      id_ready = 1'b1;
      run_n(6);
      check_eq("resume_addr", g_first, 32'h0000_0008);

      // redirect while a request is outstanding with an entry queued
      do_reset();
      id_ready = 1'b0;
      run_n(2);
      lat = 3;
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      step();
      redirect = 1'b0;
      check_eq("redir_flush", {31'd0, id_valid}, 32'd0);
      clear_obs();
      lat      = 0;
      id_ready = 1'b1;
      run_n(12);
      check_eq("redir_first_req", g_first, 32'h0000_0100);
      check_eq("redir_first_dec", d_first, 32'h0000_0100);

      // redirect coincident with the response
      do_reset();
      lat = 1;
      run_n(2);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      step();
      redirect = 1'b0;
      #1;
      check_eq("rvredir_no_push", {31'd0, id_valid}, 32'd0);
      check_eq("rvredir_idle_req", {31'd0, imem_req}, 32'd1);
      clear_obs();
      lat = 0;
      run_n(6);
      check_eq("rvredir_next", g_first, 32'h0000_0300);

      // PC wrap, then reset in the middle of a request
      do_reset();
      lat         = 0;
      id_ready    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      #1;
      check_eq("wrap_npc", npc, 32'h0000_0000);
      step();
      step();
      lat = 5;
      step();
      #2;
      clrn = 1'b1;
      #1;
      check_eq("async_rst_valid", {31'd0, id_valid}, 32'd0);
      check_eq("async_rst_req", {31'd0, imem_req}, 32'd0);
      check_eq("async_rst_pc", id_pc, 32'd0);
      model_reset();
      clear_obs();
      mem_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      clrn     = 1'b0;
      lat      = 0;
      id_ready = 1'b1;
      run_n(8);

`ifdef FETCH_ALIGN_CHECK_EN
      // misaligned redirect blocks issue and raises the flag
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      step();
      redirect = 1'b0;
      clear_obs();
      step();
      check_eq("mis_flag", {31'd0, if_misalign}, 32'd1);
      check_eq("mis_no_req", g_cnt, 0);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      step();
      redirect = 1'b0;
      check_eq("mis_clear", {31'd0, if_misalign}, 32'd0);
      run_n(4);
      check_eq("mis_resume", g_first, 32'h0000_0200);
`endif

      // randomized traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         gnt      = ($urandom_range(0, 3) != 0);
         id_ready = ($urandom_range(0, 2) != 0);
         lat      = $urandom_range(0, 2);
         redirect = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 7))
            0:       redirect_pc = 32'hFFFF_FFF8;
            1:       redirect_pc = {22'd0, 10'($urandom_range(0, 1023))};
            default: redirect_pc = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
         endcase
         step();
      end
      redirect = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
